// File: rtl/mc_ctrl_pkg.sv
// Shared constants, state/op-class enums and opcode classifier for the multi-cycle sequencer.
package mc_ctrl_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } mc_state_e;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_BEQ, CL_JAL, CL_LOAD, CL_STORE, CL_BAD
    } op_class_e;

    function automatic op_class_e classify(input logic [6:0] op);
        case (op)
            OPC_R:     return CL_R;
            OPC_I:     return CL_I;
            OPC_BEQ:   return CL_BEQ;
            OPC_JAL:   return CL_JAL;
            OPC_LOAD:  return CL_LOAD;
            OPC_STORE: return CL_STORE;
            default:   return CL_BAD;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled memory cycles; expired pulses on the WAIT_MAX-th one (never when WAIT_MAX=0).
module mc_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [W-1:0] LAST = W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + W'(1);
    end

    assign expired = (WAIT_MAX > 0) && enable && !clear && (cnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V datapath.
// Performance counters are built only when MC_CTRL_PERF_CNT_EN is defined.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_2_reg,
    output logic             busy,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output mc_state_e        state
);

    mc_state_e cur_state, nxt_state;
    op_class_e op_class, dec_class;
    logic      retire, timer_en, wait_expired;

    assign dec_class = classify(opcode);
    assign timer_en  = (cur_state == S_FETCH) || (cur_state == S_MEM);
    assign busy      = (cur_state != S_IDLE) && (cur_state != S_FAULT);
    assign state     = cur_state;

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .arst    (arst),
        .clear   (!timer_en || mem_ready),
        .enable  (timer_en),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cur_state   <= S_IDLE;
            op_class    <= CL_R;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE)
                op_class <= dec_class;
            if (cur_state == S_DECODE && dec_class == CL_BAD)
                illegal_op <= 1'b1;
            if (wait_expired)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        mem_2_reg = 1'b0;
        retire    = 1'b0;
        case (cur_state)
            S_IDLE: if (start) nxt_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = S_DECODE;
                end else if (wait_expired) begin
                    nxt_state = S_FAULT;
                end
            end
            S_DECODE: nxt_state = (dec_class == CL_BAD) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (op_class)
                    CL_R: begin
                        alu_op    = ALU_FUNCT;
                        nxt_state = S_WB;
                    end
                    CL_I: begin
                        alu_src   = 1'b1;
                        nxt_state = S_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src   = 1'b1;
                        nxt_state = S_MEM;
                    end
                    CL_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_write = zero_flag;
                        pc_src   = PC_BRANCH;
                        retire   = 1'b1;
                    end
                    CL_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        retire   = 1'b1;
                    end
                    default: nxt_state = S_FAULT;
                endcase
            end
            S_MEM: begin
                // Address (ALU add of base + imm) held stable for the whole access.
                mem_req = 1'b1;
                mem_we  = (op_class == CL_STORE);
                alu_src = 1'b1;
                if (mem_ready) begin
                    if (op_class == CL_STORE)
                        retire = 1'b1;
                    else
                        nxt_state = S_WB;
                end else if (wait_expired) begin
                    nxt_state = S_FAULT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                mem_2_reg = (op_class == CL_LOAD);
                retire    = 1'b1;
            end
            S_FAULT: nxt_state = S_FAULT;
            default: nxt_state = S_IDLE;
        endcase
        if (retire)
            nxt_state = start ? S_FETCH : S_IDLE;
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] instr_q, cycle_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            instr_q <= instr_q + CNT_W'(retire);
            cycle_q <= cycle_q + CNT_W'(busy);
        end
    end

    assign instr_cnt = instr_q;
    assign cycle_cnt = cycle_q;
`else
    assign instr_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand-built corner sequences and a
// randomized instruction stream expanded into per-cycle expectations by an instruction-level model.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    localparam int CNT_W = 32;
`ifdef MC_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0, arst = 1'b0, start = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic mem_req, mem_we, ir_write, pc_write, alu_src, reg_write, mem_2_reg, busy;
    logic illegal_op, mem_timeout;
    logic [1:0] pc_src, alu_op;
    logic [CNT_W-1:0] instr_cnt, cycle_cnt;
    mc_state_e state;

    multicycle_control #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst), .start(start), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
        .reg_write(reg_write), .mem_2_reg(mem_2_reg), .busy(busy), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write, mem_2_reg, busy;
    } ctl_t;

    typedef struct {
        logic       start, ready;
        logic [6:0] opcode;
        logic       zf;
        ctl_t       exp;
        logic       retire, set_ill, set_to;
    } vec_t;

    vec_t       trace_q[$];
    vec_t       tbl[16];
    logic [6:0] ops[6];
    int         total = 0, bad = 0;
    int         exp_ins = 0, exp_cyc = 0;
    logic       exp_ill = 1'b0, exp_to = 1'b0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctl_t ctl(input logic req, we, irw, pcw, input logic [1:0] psrc,
                                 input logic asrc, input logic [1:0] aop, input logic rw, m2r, bsy);
        ctl_t c;
        c = '{req, we, irw, pcw, psrc, asrc, aop, rw, m2r, bsy};
        return c;
    endfunction

    function automatic vec_t mk(input logic st, rd, input logic [6:0] op, input logic zf,
                                input ctl_t e, input logic ret);
        vec_t v;
        v = '{st, rd, op, zf, e, ret, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input vec_t v);
        ctl_t got;
        @(negedge clk);
        start = v.start; mem_ready = v.ready; opcode = v.opcode; zero_flag = v.zf;
        #1;
        got = '{mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op, reg_write, mem_2_reg, busy};
        check("ctl", 32'(got), 32'(v.exp));
        check("illegal_op", 32'(illegal_op), 32'(exp_ill));
        check("mem_timeout", 32'(mem_timeout), 32'(exp_to));
        check("instr_cnt", instr_cnt, PERF ? 32'(exp_ins) : 32'd0);
        check("cycle_cnt", cycle_cnt, PERF ? 32'(exp_cyc) : 32'd0);
        if (v.exp.busy) exp_cyc++;
        if (v.retire) exp_ins++;
        if (v.set_ill) exp_ill = 1'b1;
        if (v.set_to) exp_to = 1'b1;
    endtask

    task automatic run_q();
        while (trace_q.size() > 0) step(trace_q.pop_front());
    endtask

    task automatic push_idle(input logic st);
        trace_q.push_back(mk(st, rb(), 7'($urandom), rb(), '0, 1'b0));
    endtask

    task automatic push_fault(input int n);
        for (int i = 0; i < n; i++) trace_q.push_back(mk(rb(), rb(), 7'($urandom), rb(), '0, 1'b0));
    endtask

    // One instruction: fw stalled fetch cycles, mw stalled memory cycles, start value at retirement.
    task automatic push_instr(input logic [6:0] op, input int fw, input int mw, input logic zf,
                              input logic st_ret);
        vec_t v;
        logic ld, st;
        ld = (op == 7'b0000011);
        st = (op == 7'b0100011);
        for (int i = 0; i < fw; i++)
            trace_q.push_back(mk(rb(), 1'b0, 7'($urandom), rb(), ctl(1,0,0,0,2'b00,0,2'b00,0,0,1), 1'b0));
        trace_q.push_back(mk(rb(), 1'b1, 7'($urandom), rb(), ctl(1,0,1,1,2'b00,0,2'b00,0,0,1), 1'b0));
        v = mk(rb(), rb(), op, rb(), ctl(0,0,0,0,2'b00,0,2'b00,0,0,1), 1'b0);
        if (!(op inside {7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000011, 7'b0100011})) begin
            v.set_ill = 1'b1;
            trace_q.push_back(v);
        end else begin
            trace_q.push_back(v);
            case (op)
                7'b0110011: trace_q.push_back(mk(rb(), rb(), op, rb(), ctl(0,0,0,0,2'b00,0,2'b10,0,0,1), 1'b0));
                7'b1100011: trace_q.push_back(mk(st_ret, rb(), op, zf, ctl(0,0,0,zf,2'b01,0,2'b01,0,0,1), 1'b1));
                7'b1101111: trace_q.push_back(mk(st_ret, rb(), op, rb(), ctl(0,0,0,1,2'b10,0,2'b00,0,0,1), 1'b1));
                default:    trace_q.push_back(mk(rb(), rb(), op, rb(), ctl(0,0,0,0,2'b00,1,2'b00,0,0,1), 1'b0));
            endcase
            if (ld || st) begin
                for (int i = 0; i < mw; i++)
                    trace_q.push_back(mk(rb(), 1'b0, op, rb(), ctl(1,st,0,0,2'b00,1,2'b00,0,0,1), 1'b0));
                trace_q.push_back(mk(st ? st_ret : rb(), 1'b1, op, rb(),
                                     ctl(1,st,0,0,2'b00,1,2'b00,0,0,1), st));
            end
            if (op == 7'b0110011 || op == 7'b0010011 || ld)
                trace_q.push_back(mk(st_ret, rb(), op, rb(), ctl(0,0,0,0,2'b00,0,2'b00,1,ld,1), 1'b1));
        end
    endtask

    task automatic clear_model();
        exp_ins = 0; exp_cyc = 0; exp_ill = 1'b0; exp_to = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        arst = 1'b1;
        #2;
        check("rst_ctl", 32'({mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
                              reg_write, mem_2_reg, busy}), 32'd0);
        check("rst_flags", 32'({illegal_op, mem_timeout}), 32'd0);
        check("rst_cnt", instr_cnt | cycle_cnt, 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        arst = 1'b0;
        clear_model();
    endtask

    initial begin
        vec_t v;
        logic sr;
        ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000011, 7'b0100011};
        // R-type back-to-back, taken and not-taken BEQ, then a JUMP from IDLE.
        tbl[0]  = mk(1, 0, 7'h00, 0, '0, 0);
        tbl[1]  = mk(1, 1, 7'h00, 0, ctl(1,0,1,1,2'b00,0,2'b00,0,0,1), 0);
        tbl[2]  = mk(1, 0, 7'b0110011, 0, ctl(0,0,0,0,2'b00,0,2'b00,0,0,1), 0);
        tbl[3]  = mk(0, 0, 7'b0110011, 0, ctl(0,0,0,0,2'b00,0,2'b10,0,0,1), 0);
        tbl[4]  = mk(1, 0, 7'b0110011, 0, ctl(0,0,0,0,2'b00,0,2'b00,1,0,1), 1);
        tbl[5]  = mk(1, 1, 7'h00, 0, ctl(1,0,1,1,2'b00,0,2'b00,0,0,1), 0);
        tbl[6]  = mk(1, 0, 7'b1100011, 0, ctl(0,0,0,0,2'b00,0,2'b00,0,0,1), 0);
        tbl[7]  = mk(1, 0, 7'b1100011, 1, ctl(0,0,0,1,2'b01,0,2'b01,0,0,1), 1);
        tbl[8]  = mk(1, 1, 7'h00, 0, ctl(1,0,1,1,2'b00,0,2'b00,0,0,1), 0);
        tbl[9]  = mk(1, 0, 7'b1100011, 0, ctl(0,0,0,0,2'b00,0,2'b00,0,0,1), 0);
        tbl[10] = mk(0, 0, 7'b1100011, 0, ctl(0,0,0,0,2'b01,0,2'b01,0,0,1), 1);
        tbl[11] = mk(1, 0, 7'h00, 0, '0, 0);
        tbl[12] = mk(0, 1, 7'h00, 0, ctl(1,0,1,1,2'b00,0,2'b00,0,0,1), 0);
        tbl[13] = mk(0, 0, 7'b1101111, 0, ctl(0,0,0,0,2'b00,0,2'b00,0,0,1), 0);
        tbl[14] = mk(0, 0, 7'b1101111, 0, ctl(0,0,0,1,2'b10,0,2'b00,0,0,1), 1);
        tbl[15] = mk(0, 1, 7'h00, 0, '0, 0);

        do_reset();
        for (int i = 0; i < 16; i++) step(tbl[i]);

        // LOAD with three stalled memory cycles.
        push_idle(1'b1);
        push_instr(7'b0000011, 0, 3, 1'b0, 1'b0);
        push_idle(1'b0);
        run_q();

        // Random instruction stream with fetch/memory stalls below the timeout.
        push_idle(1'b1);
        for (int n = 0; n < 60; n++) begin
            sr = (n == 59) ? 1'b0 : ($urandom_range(0, 3) != 0);
            push_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), rb(), sr);
            if (!sr && n != 59) begin
                repeat ($urandom_range(0, 2)) push_idle(1'b0);
                push_idle(1'b1);
            end
        end
        push_idle(1'b0);
        run_q();

        // Illegal opcode parks the sequencer in FAULT.
        push_idle(1'b1);
        push_instr(7'b1111111, 0, 0, 1'b0, 1'b1);
        push_fault(5);
        run_q();
        do_reset();

        // Fetch never acknowledged: fault after four stalled cycles.
        push_idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            v = mk(1'b1, 1'b0, 7'h00, 1'b0, ctl(1,0,0,0,2'b00,0,2'b00,0,0,1), 1'b0);
            v.set_to = (i == 3);
            trace_q.push_back(v);
        end
        push_fault(4);
        run_q();
        do_reset();

        // Reset asserted during write-back drops reg_write immediately.
        push_idle(1'b1);
        push_instr(7'b0110011, 0, 0, 1'b0, 1'b1);
        v = trace_q.pop_back();
        run_q();
        step(v);
        #1 arst = 1'b1;
        #1;
        check("wb_rst_reg_write", 32'(reg_write), 32'd0);
        check("wb_rst_busy_req", 32'({busy, mem_req, mem_we}), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        clear_model();

        // Ten R-types back to back for the performance counters.
        do_reset();
        push_idle(1'b1);
        for (int i = 0; i < 10; i++) push_instr(7'b0110011, 0, 0, 1'b0, i < 9);
        push_idle(1'b0);
        run_q();
        check("instr_cnt_10", instr_cnt, PERF ? 32'd10 : 32'd0);
        check("cycle_cnt_40", cycle_cnt, PERF ? 32'd40 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
